// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall encodings, exception codes and FSM states for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] EXC_ERET  = 32'h0000_000e;

    // Each request stalls its own stage and every stage upstream of it.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        RUN  = 1'b0,
        MASK = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (inc && !(&q))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, turns MEM exceptions into flush + redirect,
// masks squashed-stage requests for one cycle after a flush, and keeps a stall watchdog and perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          WDOG_MAX   = 1023,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             ex_annul,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WW = $clog2(WDOG_MAX + 1);

    state_e        state_q, state_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout_d;
    logic          req_id, req_ex, stall_any;

    always_comb begin
        flush     = rst_n && (excepttype_i != ZERO_WORD);
        req_id    = stallreq_id && (state_q == RUN);
        req_ex    = stallreq_ex && (state_q == RUN);
        stall     = (!rst_n || flush) ? STALL_NONE :
                    stallreq_mem      ? STALL_MEM  :
                    req_ex            ? STALL_EX   :
                    req_id            ? STALL_ID   :
                    stallreq_if       ? STALL_IF   : STALL_NONE;
        new_pc    = !flush ? ZERO_WORD : (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
        ex_annul  = flush;
        stall_any = |stall;
        state_d   = flush ? MASK : RUN;
        wdog_d    = !stall_any ? '0 : (wdog_q == WW'(WDOG_MAX)) ? wdog_q : wdog_q + 1'b1;
        timeout_d = stall_timeout | (wdog_d == WW'(WDOG_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wdog_q        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            stall_timeout <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (stall_any),
        .q    (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (flush),
        .q    (flush_count)
    );

endmodule
